// File: rtl/interleaver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// interleaver : 802.11a TX block interleaver, ping-pong 192-bit buffers
// Revision 1.0
// ---------------------------------------------------------------------------
module interleaver (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEN,
  input  logic       iRateEN,
  input  logic [3:0] iRate,
  input  logic       iData,
  output logic       oData,
  output logic       oValid
);

  localparam logic [1:0] MODE_BPSK = 2'd0;
  localparam logic [1:0] MODE_QPSK = 2'd1;
  localparam logic [1:0] MODE_QAM  = 2'd2;

  logic [3:0]   rate;
  logic [3:0]   c_cnt;
  logic [3:0]   r_cnt;
  logic         sel;
  logic         out_en;
  logic [191:0] b_buf;
  logic [191:0] f_buf;

  logic [1:0]   mode;
  logic [3:0]   r_last;
  logic [7:0]   c_x3;
  logic [7:0]   ni_c;
  logic [7:0]   addr_i;
  logic [7:0]   addr_j;
  logic [7:0]   addr_k;
  logic         eos;

  always_comb begin
    mode   = MODE_BPSK;
    r_last = 4'd2;
    case (rate)
      4'b1101, 4'b1111: begin mode = MODE_BPSK; r_last = 4'd2;  end
      4'b0101, 4'b0111: begin mode = MODE_QPSK; r_last = 4'd5;  end
      4'b1001, 4'b1011: begin mode = MODE_QAM;  r_last = 4'd11; end
      default:          begin mode = MODE_BPSK; r_last = 4'd2;  end
    endcase
  end

  // Ni*c built from 3c so no multiplier is needed
  always_comb begin
    c_x3 = ({4'b0000, c_cnt} << 1) + {4'b0000, c_cnt};
    ni_c = c_x3;
    case (mode)
      MODE_QPSK: ni_c = c_x3 << 1;
      MODE_QAM:  ni_c = c_x3 << 2;
      default:   ni_c = c_x3;
    endcase
    addr_i = ni_c + {4'b0000, r_cnt};
    addr_j = (mode == MODE_QAM) ? {addr_i[7:1], addr_i[0] ^ c_cnt[0]} : addr_i;
    addr_k = {r_cnt, c_cnt};
    eos    = (c_cnt == 4'hF) && (r_cnt == r_last);
  end

  assign oData  = sel ? b_buf[addr_k] : f_buf[addr_k];
  assign oValid = iEN & out_en;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rate   <= 4'b1101;
      c_cnt  <= 4'd0;
      r_cnt  <= 4'd0;
      sel    <= 1'b0;
      out_en <= 1'b0;
      b_buf  <= '0;
      f_buf  <= '0;
    end else if (iRateEN) begin
      rate   <= iRate;
      c_cnt  <= 4'd0;
      r_cnt  <= 4'd0;
      sel    <= 1'b0;
      out_en <= 1'b0;
    end else if (iEN) begin
      if (sel) f_buf[addr_j] <= iData;
      else     b_buf[addr_j] <= iData;
      c_cnt <= c_cnt + 4'd1;
      if (c_cnt == 4'hF) r_cnt <= eos ? 4'd0 : r_cnt + 4'd1;
      if (eos) begin
        sel    <= ~sel;
        out_en <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/interleaver.md
# interleaver

TX-side block interleaver for the 802.11a PHY, inverse of the RX deinterleaver. Serial coded bits from the convolutional encoder/puncturer are permuted per OFDM symbol (Ncbps = 48, 96 or 192 bits) and streamed serially to the symbol mapper. It uses ping-pong 192-bit buffers, so one symbol is written while the previous one is read out, with no throughput loss.

## Interface
- No parameters; buffer depth is fixed at 192 bits.
- iClk  input  1  clock (fast); all logic on the rising edge
- iRst  input  1  reset, synchronous, active-high
- iEN  input  1  bit strobe; qualifies iData and advances the output stream
- iRateEN  input  1  rate load strobe; loads iRate and restarts symbol alignment
- iRate  input  4  802.11a RATE field
- iData  input  1  serial coded input bit
- oData  output  1  serial interleaved output bit
- oValid  output  1  oData valid indicator

## Operation
- Rate register RATE:
  - Resets to 4'b1101 (6 Mbps).
  - Loads iRate when iRateEN=1.
- Mode decode from RATE:
  - 1101 / 1111 (6/9): BPSK, Ni=3, Ncbps=48.
  - 0101 / 0111 (12/18): QPSK, Ni=6, Ncbps=96.
  - 1001 / 1011 (24/36): 16-QAM, Ni=12, Ncbps=192.
  - Any other code (48/54 Mbps, illegal): treated as BPSK.
- Counters (4-bit each):
  - cCnt: 0..15, increments on every iEN.
  - rCnt: 0..Ni-1, increments when cCnt=15 and iEN=1.
  - End of symbol: iEN=1 with cCnt=15 and rCnt=Ni-1.
  - Input bit index k = 16*rCnt + cCnt (8 bits).
- Write address (first and second 802.11a permutations):
  - i = Ni*cCnt + rCnt, 8 bits, max 191. Ni*cCnt is formed from shifts and adds: 3c = (c<<1)+c, 6c = 3c<<1, 12c = 3c<<2.
  - BPSK/QPSK: j = i.
  - 16-QAM: j = {i[7:1], i[0]^cCnt[0]}.
- Buffers:
  - selReg=0: write bBuf[j] <= iData; read fBuf.
  - selReg=1: write fBuf[j] <= iData; read bBuf.
  - Read address is k: oData = readBuf[k], combinational.
  - selReg toggles at end of symbol.
- OUT_EN:
  - Cleared by reset and by iRateEN.
  - Set at the first end of symbol.
  - oValid = iEN & OUT_EN.
- iRateEN=1 in a cycle:
  - Loads RATE.
  - Zeroes cCnt, rCnt and selReg.
  - Clears OUT_EN.
  - Drops any iEN bit in the same cycle (iRateEN has priority). No buffer write occurs.
- iEN=0: counters, buffers and selReg hold.

## Timing
- Reset state:
  - oData=0, oValid=0.
  - RATE=1101.
  - cCnt=rCnt=0, selReg=0, OUT_EN=0.
  - Both buffers cleared to 0.
- Latency is exactly Ncbps iEN-qualified cycles. Input bit k of symbol n appears at output position j(k) of the output window of symbol n+1.
- First valid output: the iEN cycle immediately after the first end of symbol (i.e. the (Ncbps+1)th iEN after reset or rate load).
- Output position p of a symbol is presented in the cycle where k=p, concurrent with the write of input bit p of the next symbol.
- Wrap-around: at end of symbol, cCnt and rCnt return to 0 on the same edge that toggles selReg. The next cycle reads the freshly written buffer from index 0.
- Gaps in iEN stall both streams with no loss. oValid=0 during gaps.
- Changing the rate mid-symbol discards the partial symbol and any buffered symbol. oValid stays 0 until a full new symbol has been written.
- Reset asserted mid-symbol behaves identically to power-on reset on the next edge.
- Simultaneous iRst and iRateEN: reset wins; RATE=1101.

## Test plan
- BPSK, one-hot input at k=1 (cCnt=1, rCnt=0) in symbol 0, iEN continuous -> symbol-1 output window has a single 1 at p=3. oValid first rises at iEN cycle 49.
- QPSK, one-hot at k=17 (cCnt=1, rCnt=1) -> single 1 at p=7 (6+1). One-hot at k=95 -> single 1 at p=95.
- 16-QAM, one-hot at k=1 -> single 1 at p=13 (12 with LSB flipped). One-hot at k=16 -> single 1 at p=1. Random 192-bit symbols streamed back-to-back -> output matches the reference permutation model for every symbol with no gaps.
- iEN duty 1/3 with random gaps, 16-QAM -> same output sequence as the continuous run. oValid=0 exactly on gap cycles.
- iRateEN pulse at k=40 of a QPSK symbol, switching to 16-QAM -> oValid drops the next cycle and stays 0 for 192 iEN cycles, then the 16-QAM output is correct. An iEN bit coincident with the pulse is not written.
- iRst pulse mid-stream, 16-QAM -> the next cycle shows oValid=0, RATE=1101, counters zero. After 48 iEN cycles, BPSK output starts correctly.
